// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: immediate-encode request in,
// registered instruction word and error flags out.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ImmSel;
  logic [31:0] imm_in;
  logic [31:0] base_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst_out;
  logic        err_range;
  logic        err_align;

  modport master (
    output in_valid, ImmSel, imm_in, base_inst, out_ready,
    input  in_ready, out_valid, inst_out, err_range, err_align
  );

  modport slave (
    input  in_valid, ImmSel, imm_in, base_inst, out_ready,
    output in_ready, out_valid, inst_out, err_range, err_align
  );
endinterface

// File: rtl/imm_encoder.sv
// Scatters an immediate into a RISC-V template instruction (U/I/S/B/J).
// Define IMM_ENCODER_SPLIT_EN to split out-of-range ADDI into LUI + ADDI.
//
// state    | meaning
// IDLE     | no word held, ready for a request
// HOLD     | one encoded word presented on the output
// SPLIT_HI | LUI half of a split ADDI presented, ADDI half pending
// SPLIT_LO | ADDI half of a split presented
module imm_encoder (
  input  logic         clk,
  input  logic         rst_n,
  imm_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1
`ifdef IMM_ENCODER_SPLIT_EN
    ,
    SPLIT_HI = 2'd2,
    SPLIT_LO = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        err_r_q, err_r_d;
  logic        err_a_q, err_a_d;
  logic [31:0] enc;
  logic        enc_err_r;
  logic        enc_err_a;
  logic        rdy;
  logic        accept;

  wire [31:0] imm  = bus.imm_in;
  wire [31:0] base = bus.base_inst;

  // Field assignment over the template both clears and fills the immediate bits.
  always_comb begin
    enc       = base;
    enc_err_r = 1'b0;
    enc_err_a = 1'b0;
    case (bus.ImmSel)
      3'b000: begin
        enc[31:12] = imm[31:12];
        enc_err_r  = |imm[11:0];
      end
      3'b001: begin
        enc[31:20] = imm[11:0];
        enc_err_r  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      3'b010: begin
        enc[31:25] = imm[11:5];
        enc[11:7]  = imm[4:0];
        enc_err_r  = !((&imm[31:11]) || !(|imm[31:11]));
      end
      3'b011: begin
        enc[31:25] = {imm[12], imm[10:5]};
        enc[11:7]  = {imm[4:1], imm[11]};
        enc_err_r  = !((&imm[31:12]) || !(|imm[31:12]));
        enc_err_a  = imm[0];
      end
      3'b100: begin
        enc[31:12] = {imm[20], imm[10:1], imm[11], imm[19:12]};
        enc_err_r  = !((&imm[31:20]) || !(|imm[31:20]));
        enc_err_a  = imm[0];
      end
      default: begin
        enc       = base;
        enc_err_r = 1'b1;
      end
    endcase
  end

`ifdef IMM_ENCODER_SPLIT_EN
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_sum;
  logic [31:0] lui_word;
  logic [31:0] addi_word;
  logic        do_split;

  // Rounding by 0x800 compensates for the sign extension of the low 12 bits.
  assign hi_sum    = imm + 32'h0000_0800;
  assign lui_word  = {hi_sum[31:12], base[11:7], 7'b0110111};
  assign addi_word = {imm[11:0], base[11:7], base[14:12], base[11:7], base[6:0]};
  assign do_split  = (bus.ImmSel == 3'b001) && enc_err_r &&
                     (base[6:0] == 7'b0010011) && (base[14:12] == 3'b000);
`endif

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    err_r_d = err_r_q;
    err_a_d = err_a_q;
    rdy     = 1'b0;
`ifdef IMM_ENCODER_SPLIT_EN
    lo_d    = lo_q;
`endif
    case (state_q)
      IDLE:     rdy = 1'b1;
      HOLD:     rdy = bus.out_ready;
`ifdef IMM_ENCODER_SPLIT_EN
      SPLIT_HI: rdy = 1'b0;
      SPLIT_LO: rdy = bus.out_ready;
`endif
      default:  rdy = 1'b0;
    endcase
    accept = bus.in_valid && rdy;

    if (accept) begin
      state_d = HOLD;
      inst_d  = enc;
      err_r_d = enc_err_r;
      err_a_d = enc_err_a;
`ifdef IMM_ENCODER_SPLIT_EN
      if (do_split) begin
        state_d = SPLIT_HI;
        inst_d  = lui_word;
        err_r_d = 1'b0;
        err_a_d = 1'b0;
        lo_d    = addi_word;
      end
`endif
    end else begin
      case (state_q)
        HOLD:     if (bus.out_ready) state_d = IDLE;
`ifdef IMM_ENCODER_SPLIT_EN
        SPLIT_HI: if (bus.out_ready) begin
          state_d = SPLIT_LO;
          inst_d  = lo_q;
          err_r_d = 1'b0;
          err_a_d = 1'b0;
        end
        SPLIT_LO: if (bus.out_ready) state_d = IDLE;
`endif
        IDLE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inst_q  <= 32'h0;
      err_r_q <= 1'b0;
      err_a_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      err_r_q <= err_r_d;
      err_a_q <= err_a_d;
    end
  end

`ifdef IMM_ENCODER_SPLIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lo_q <= 32'h0;
    else        lo_q <= lo_d;
  end
`endif

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state_q != IDLE);
  assign bus.inst_out  = inst_q;
  assign bus.err_range = err_r_q;
  assign bus.err_align = err_a_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder; split expectations follow IMM_ENCODER_SPLIT_EN.
module tb_imm_encoder;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  imm_encoder_if bus ();

  imm_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request from IDLE; returns 1 ns after the accepting edge.
  task automatic send(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    bus.ImmSel    = sel;
    bus.imm_in    = imm;
    bus.base_inst = base;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({bus.out_valid, bus.inst_out, bus.err_range, bus.err_align} !== 35'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b inst=%h er=%b ea=%b, want all zero",
               bus.out_valid, bus.inst_out, bus.err_range, bus.err_align);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_encode();
    // sel, imm, base, expected inst, err_range, err_align
    logic [2:0]  sel [9];
    logic [31:0] imm [9];
    logic [31:0] base[9];
    logic [31:0] x_inst[9];
    logic        x_er[9];
    logic        x_ea[9];
    sel[0]=3'b001; imm[0]=32'hFFFFF800; base[0]=32'h00000013; x_inst[0]=32'h80000013; x_er[0]=0; x_ea[0]=0;
    sel[1]=3'b010; imm[1]=32'h000007FF; base[1]=32'h00002023; x_inst[1]=32'h7E002FA3; x_er[1]=0; x_ea[1]=0;
    sel[2]=3'b011; imm[2]=32'hFFFFFFFE; base[2]=32'h00000063; x_inst[2]=32'hFE000FE3; x_er[2]=0; x_ea[2]=0;
    sel[3]=3'b011; imm[3]=32'h00000003; base[3]=32'h00000063; x_inst[3]=32'h00000163; x_er[3]=0; x_ea[3]=1;
    sel[4]=3'b000; imm[4]=32'h00000001; base[4]=32'h00000037; x_inst[4]=32'h00000037; x_er[4]=1; x_ea[4]=0;
    sel[5]=3'b100; imm[5]=32'h00000800; base[5]=32'h0000006F; x_inst[5]=32'h0010006F; x_er[5]=0; x_ea[5]=0;
    sel[6]=3'b100; imm[6]=32'h00100000; base[6]=32'h0000006F; x_inst[6]=32'h8000006F; x_er[6]=1; x_ea[6]=0;
    sel[7]=3'b001; imm[7]=32'h00000800; base[7]=32'h00002013; x_inst[7]=32'h80002013; x_er[7]=1; x_ea[7]=0;
    sel[8]=3'b101; imm[8]=32'hDEADBEEF; base[8]=32'h01234567; x_inst[8]=32'h01234567; x_er[8]=1; x_ea[8]=0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(sel[i], imm[i], base[i]);
      n_cmp++;
      if ({bus.out_valid, bus.inst_out, bus.err_range, bus.err_align} !==
          {1'b1, x_inst[i], x_er[i], x_ea[i]}) begin
        n_err++;
        $display("FAIL encode_%0d: got v=%b inst=%h er=%b ea=%b, want v=1 inst=%h er=%b ea=%b",
                 i, bus.out_valid, bus.inst_out, bus.err_range, bus.err_align,
                 x_inst[i], x_er[i], x_ea[i]);
      end
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL drain_%0d: out_valid got %b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(3'b010, 32'h000007FF, 32'h00002023);
    bus.ImmSel = 3'b001; bus.imm_in = 32'hFFFFF800; bus.base_inst = 32'h00000013;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({bus.out_valid, bus.inst_out, bus.in_ready} !== {1'b1, 32'h7E002FA3, 1'b0}) begin
        n_err++;
        $display("FAIL stall_%0d: got v=%b inst=%h in_ready=%b, want v=1 inst=7e002fa3 in_ready=0",
                 i, bus.out_valid, bus.inst_out, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    step();
    n_cmp++;
    if ({bus.out_valid, bus.inst_out} !== {1'b1, 32'h80000013}) begin
      n_err++;
      $display("FAIL b2b_first: got v=%b inst=%h want v=1 inst=80000013", bus.out_valid, bus.inst_out);
    end
    bus.ImmSel = 3'b011; bus.imm_in = 32'hFFFFFFFE; bus.base_inst = 32'h00000063;
    step();
    n_cmp++;
    if ({bus.out_valid, bus.inst_out} !== {1'b1, 32'hFE000FE3}) begin
      n_err++;
      $display("FAIL b2b_second: got v=%b inst=%h want v=1 inst=fe000fe3", bus.out_valid, bus.inst_out);
    end
    bus.in_valid = 1'b0;
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_split();
    bus.out_ready = 1'b1;
    send(3'b001, 32'h12345FFF, 32'h00000513);
`ifdef IMM_ENCODER_SPLIT_EN
    n_cmp++;
    if ({bus.out_valid, bus.inst_out, bus.err_range, bus.err_align, bus.in_ready} !==
        {1'b1, 32'h12346537, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL split_hi: got v=%b inst=%h er=%b ea=%b rdy=%b, want v=1 inst=12346537 er=0 ea=0 rdy=0",
               bus.out_valid, bus.inst_out, bus.err_range, bus.err_align, bus.in_ready);
    end
    step();
    n_cmp++;
    if ({bus.out_valid, bus.inst_out, bus.err_range, bus.err_align} !==
        {1'b1, 32'hFFF50513, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL split_lo: got v=%b inst=%h er=%b ea=%b, want v=1 inst=fff50513 er=0 ea=0",
               bus.out_valid, bus.inst_out, bus.err_range, bus.err_align);
    end
`else
    n_cmp++;
    if ({bus.out_valid, bus.inst_out, bus.err_range, bus.err_align} !==
        {1'b1, 32'hFFF00513, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL nosplit: got v=%b inst=%h er=%b ea=%b, want v=1 inst=fff00513 er=1 ea=0",
               bus.out_valid, bus.inst_out, bus.err_range, bus.err_align);
    end
`endif
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL split_drain: out_valid got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_split();
    bus.out_ready = 1'b0;
    send(3'b001, 32'h12345FFF, 32'h00000513);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.inst_out} !== 33'h0) begin
      n_err++;
      $display("FAIL rst_mid: got v=%b inst=%h want v=0 inst=0", bus.out_valid, bus.inst_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.inst_out === 32'hFFF50513) begin
        n_err++;
        $display("FAIL rst_no_tail_%0d: got v=%b inst=%h want v=0 and no fff50513",
                 i, bus.out_valid, bus.inst_out);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.in_valid  = 1'b0;
    bus.ImmSel    = 3'b000;
    bus.imm_in    = 32'h0;
    bus.base_inst = 32'h0;
    bus.out_ready = 1'b1;
    test_reset();
    test_encode();
    test_backpressure();
    test_split();
    test_reset_mid_split();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-004 The block SHALL have port in_ready, output, 1 bit: request accepted when in_valid && in_ready at a clock edge.
REQ-005 The block SHALL have port ImmSel, input, 3 bits: 000 U, 001 I, 010 S, 011 B, 100 J; 101-111 invalid.
REQ-006 The block SHALL have port imm_in, input, 32 bits: sign-extended immediate value (byte offset for B/J).
REQ-007 The block SHALL have port base_inst, input, 32 bits: template instruction; all non-immediate bits are preserved.
REQ-008 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): output handshake; transfer occurs on out_valid && out_ready.
REQ-009 The block SHALL have port inst_out, output, 32 bits: encoded instruction word, registered.
REQ-010 The block SHALL have ports err_range and err_align, outputs, 1 bit each: per-word flags, valid with out_valid.

Function
REQ-011 The block SHALL clear the immediate bit positions of base_inst for the selected format and scatter imm_in into them: I [31:20]=imm[11:0]; S [31:25]=imm[11:5], [11:7]=imm[4:0]; B [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; J [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]; U [31:12]=imm[31:12].
REQ-012 The block SHALL set err_range for I/S when imm_in[31:11] are not all equal, for B when imm_in[31:12] are not all equal, for J when imm_in[31:20] are not all equal, and for U when imm_in[11:0]!=0; the truncated encoding is still output.
REQ-013 The block SHALL set err_align for B/J when imm_in[0]=1; bit 0 is dropped.
REQ-014 The block SHALL output inst_out=base_inst with err_range=1 for an invalid ImmSel.
REQ-015 The block SHALL use states IDLE, HOLD, SPLIT_HI and SPLIT_LO; out_valid=1 in every state except IDLE.
REQ-016 The block SHALL drive in_ready=1 in IDLE, and in HOLD or SPLIT_LO when out_ready=1; in_ready=0 in SPLIT_HI.
REQ-017 The block SHALL register the result one cycle after acceptance (latency 1), and SHALL sustain one word per cycle when out_ready is held at 1.
REQ-018 The block SHALL hold inst_out, err_range and err_align stable while out_valid && !out_ready.
REQ-019 On acceptance, the block SHALL enter HOLD (or SPLIT_HI per REQ-024); after a transfer with no new acceptance, HOLD and SPLIT_LO SHALL return to IDLE.
REQ-020 A simultaneous output transfer and input acceptance SHALL load the new word with no bubble.

Reset
REQ-021 On rst_n low, the block SHALL asynchronously force state IDLE, out_valid=0, inst_out=0, err_range=0 and err_align=0; in_ready SHALL read 1 once reset is released.
REQ-022 Reset asserted in SPLIT_HI or SPLIT_LO SHALL discard the pending word; no partial pair SHALL be emitted after reset.

Configuration
REQ-023 The macro IMM_ENCODER_SPLIT_EN SHALL select whether large I-type immediates are split.
REQ-024 With IMM_ENCODER_SPLIT_EN defined, an I-type request that fails range, with base_inst[6:0]=0010011 and [14:12]=000 (ADDI), SHALL emit two words:
- First, in SPLIT_HI: LUI with opcode 0110111, rd=base_inst[11:7] and [31:12]=(imm_in+0x800)[31:12].
- Then, in SPLIT_LO: the ADDI, with rs1 replaced by rd and imm[11:0], and err_range=0 on both words.
REQ-025 Without IMM_ENCODER_SPLIT_EN, SPLIT_HI and SPLIT_LO SHALL be absent, and such requests SHALL follow REQ-012.

Verification
REQ-026 The bench SHALL cover I-type: ImmSel=001, imm=0xFFFFF800, base=0x00000013 -> inst_out=0x80000013, errors 0.
REQ-027 The bench SHALL cover S-type: ImmSel=010, imm=0x000007FF, base=0x00002023 -> 0x7E002FA3; and B-type: ImmSel=011, imm=0xFFFFFFFE, base=0x00000063 -> 0xFE000FE3.
REQ-028 The bench SHALL cover B-type alignment: imm=0x00000003 -> err_align=1; and U-type: imm=0x00000001 -> err_range=1.
REQ-029 The bench SHALL cover backpressure: out_ready=0 for 3 cycles -> inst_out stable and in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back words.
REQ-030 The bench SHALL cover split with the macro defined: ImmSel=001, imm=0x12345FFF, base=0x00000513 -> 0x12346537 then 0xFFF50513; without the macro -> 0xFFF00513 with err_range=1.
REQ-031 The bench SHALL cover reset mid-split: rst_n low while in SPLIT_HI -> out_valid=0 immediately; after release, no 0xFFF50513 word appears.
